// File: rtl/ppi_strobed.sv
`default_nettype none
// ============================================================================
//  Module      : ppi_strobed
//  Description : Two-port parallel peripheral interface with basic and
//                strobed (handshaked) input/output modes, CPU register
//                access, per-port interrupts and input overrun detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppi_strobed #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [1:0]    addr,
    input  logic [7:0]    idata,
    output logic [7:0]    odata,
    input  logic          cs,
    input  logic          we,
    input  logic          oe,
    input  logic [DW-1:0] ipa,
    input  logic [DW-1:0] ipb,
    output logic [DW-1:0] opa,
    output logic [DW-1:0] opb,
    input  logic [1:0]    stb_n,
    input  logic [1:0]    ack_n,
    output logic [1:0]    ibf,
    output logic [1:0]    obf_n,
    output logic [1:0]    intr,
    output logic          irq
);

    localparam logic [7:0] CTRL_RESET = 8'h05;

    logic [7:0]             ctrl;
    logic [DW-1:0]          out_lat [2];
    logic [DW-1:0]          in_lat  [2];
    logic [DW-1:0]          ip_pin  [2];
    logic [7:0]             port_val [2];
    logic [1:0]             ibf_r, obf_r, intr_r, ovr_r, pend_r;
    logic                   wr_d, rd_d, wr_ev, rd_ev, ctrl_wr, stat_rd;
    logic [SYNC_STAGES-1:0] stb_sync [2];
    logic [SYNC_STAGES-1:0] ack_sync [2];
    logic [1:0]             stb_s, ack_s, stb_prev, ack_prev;
    logic [1:0]             stb_fall, stb_rise, ack_fall, ack_rise;
    logic [1:0]             is_in, strobed, inte, s_in, s_out, port_wr, port_rd;
    logic [1:0]             ibf_set, ibf_clr, obf_set, obf_clr;
    logic [1:0]             intr_set, intr_clr, ovr_set, load_in, pend_clr;

    assign ip_pin[0] = ipa;
    assign ip_pin[1] = ipb;

    // Delayed copies of the CPU strobes so each strobe acts once per rising edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_d <= 1'b0;
            rd_d <= 1'b0;
        end else begin
            wr_d <= we & cs;
            rd_d <= oe & cs;
        end
    end

    // Handshake pin synchronisers plus previous-value registers for edge detection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                stb_sync[p] <= '1;
                ack_sync[p] <= '1;
            end
            stb_prev <= 2'b11;
            ack_prev <= 2'b11;
        end else begin
            for (int p = 0; p < 2; p++) begin
                stb_sync[p] <= {stb_sync[p][SYNC_STAGES-2:0], stb_n[p]};
                ack_sync[p] <= {ack_sync[p][SYNC_STAGES-2:0], ack_n[p]};
            end
            stb_prev <= stb_s;
            ack_prev <= ack_s;
        end
    end

    // Event decode and per-port set/clear terms for the handshake flags
    always_comb begin
        wr_ev   = we & cs & ~wr_d;
        rd_ev   = oe & cs & ~rd_d;
        ctrl_wr = wr_ev && (addr == 2'd3);
        stat_rd = rd_ev && (addr == 2'd2);
        stb_s   = '0;
        ack_s   = '0;
        is_in   = '0;
        strobed = '0;
        inte    = '0;
        port_wr = '0;
        port_rd = '0;
        for (int p = 0; p < 2; p++) begin
            stb_s[p]   = stb_sync[p][SYNC_STAGES-1];
            ack_s[p]   = ack_sync[p][SYNC_STAGES-1];
            is_in[p]   = ctrl[2*p];
            strobed[p] = ctrl[2*p+1];
            inte[p]    = ctrl[4+p];
            port_wr[p] = wr_ev && (addr == 2'(p));
            port_rd[p] = rd_ev && (addr == 2'(p));
        end
        stb_fall = stb_prev & ~stb_s;
        stb_rise = ~stb_prev & stb_s;
        ack_fall = ack_prev & ~ack_s;
        ack_rise = ~ack_prev & ack_s;
        s_in     = is_in & strobed;
        s_out    = ~is_in & strobed;
        // A falling strobe always (re)asserts ibf so a coincident read cannot drop it
        ibf_set  = s_in & stb_fall;
        ibf_clr  = s_in & port_rd;
        load_in  = s_in & stb_fall & ~ibf_r;
        ovr_set  = s_in & stb_fall & ibf_r;
        obf_set  = s_out & port_wr;
        obf_clr  = s_out & ack_fall & obf_r;
        pend_clr = s_out & ack_rise & pend_r;
        intr_set = inte & ((s_in & stb_rise & ibf_r) | pend_clr);
        intr_clr = (s_in & port_rd) | (s_out & port_wr);
    end

    // Control word, output latches and handshake flags; a control write resets the handshake
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ctrl       <= CTRL_RESET;
            out_lat[0] <= '0;
            out_lat[1] <= '0;
            ibf_r      <= '0;
            obf_r      <= '0;
            intr_r     <= '0;
            ovr_r      <= '0;
            pend_r     <= '0;
        end else if (ctrl_wr) begin
            ctrl       <= idata;
            out_lat[0] <= '0;
            out_lat[1] <= '0;
            ibf_r      <= '0;
            obf_r      <= '0;
            intr_r     <= '0;
            ovr_r      <= '0;
            pend_r     <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (port_wr[p]) out_lat[p] <= idata[DW-1:0];
            end
            ibf_r  <= ibf_set  | (ibf_r  & ~ibf_clr);
            obf_r  <= obf_set  | (obf_r  & ~obf_clr);
            intr_r <= intr_set | (intr_r & ~intr_clr);
            pend_r <= obf_clr  | (pend_r & ~pend_clr);
            ovr_r  <= ovr_set  | (ovr_r  & ~{2{stat_rd}});
        end
    end

    // Input latches capture the pins on an accepted strobe
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in_lat[0] <= '0;
            in_lat[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (load_in[p]) in_lat[p] <= ip_pin[p];
            end
        end
    end

    // CPU read multiplexer; the bus idles high when not being read
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            port_val[p] = 8'h00;
            if (!is_in[p])      port_val[p][DW-1:0] = out_lat[p];
            else if (strobed[p]) port_val[p][DW-1:0] = in_lat[p];
            else                 port_val[p][DW-1:0] = ip_pin[p];
        end
        odata = 8'hFF;
        if (oe & cs) begin
            case (addr)
                2'd0:    odata = port_val[0];
                2'd1:    odata = port_val[1];
                2'd2:    odata = {ovr_r[1], ovr_r[0], intr_r[1], obf_r[1], ibf_r[1],
                                  intr_r[0], obf_r[0], ibf_r[0]};
                default: odata = ctrl;
            endcase
        end
    end

    assign opa   = is_in[0] ? '1 : out_lat[0];
    assign opb   = is_in[1] ? '1 : out_lat[1];
    assign ibf   = ibf_r;
    assign obf_n = ~obf_r;
    assign intr  = intr_r;
    assign irq   = intr_r[0] | intr_r[1];

endmodule
`default_nettype wire
